// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer
//  Purpose  : Multi-frame acquisition scheduler. Issues single-cycle capture
//             pulses to the camera capture controller, waits for each frame's
//             DMA completion, enforces a minimum capture-to-capture interval
//             and a per-frame watchdog, and supports abort.
//  Ports    : sys_clk, sys_rst (async, active-high)
//             start, abort              - control pulses
//             frame_count               - frames to acquire (0 = continuous)
//             frame_interval            - min cycles capture to capture
//             timeout_cycles            - max cycles capture to frame_done
//                                         (0 = watchdog disabled)
//             frame_done                - DMA tlast handshake pulse
//             capture, done             - single-cycle output pulses
//             busy                      - sequence in progress
//             frames_done               - frames completed this sequence
//             timeout_err               - sticky watchdog flag
//  Revision : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
    parameter int CNT_W = 32,
    parameter int FRM_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [FRM_W-1:0] frame_count,
    input  logic [CNT_W-1:0] frame_interval,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic             frame_done,
    output logic             capture,
    output logic             busy,
    output logic             done,
    output logic [FRM_W-1:0] frames_done,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        CAPTURE       = 3'd1,
        WAIT_FRAME    = 3'd2,
        WAIT_INTERVAL = 3'd3,
        FINISH        = 3'd4
    } state_t;

    localparam logic [CNT_W:0]   c_cnt_one_ext = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_one     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_zero    = '0;
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;
    localparam logic [FRM_W-1:0] c_frm_one     = {{(FRM_W-1){1'b0}}, 1'b1};
    localparam logic [FRM_W-1:0] c_frm_zero    = '0;

    state_t           r_state;
    state_t           w_next;

    logic [FRM_W-1:0] r_count_lat;
    logic [CNT_W-1:0] r_interval_lat;
    logic [CNT_W-1:0] r_timeout_lat;
    logic [CNT_W-1:0] r_int_cnt;
    logic [CNT_W-1:0] r_to_cnt;
    logic [FRM_W-1:0] r_frames;
    logic             r_capture;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout_err;

    logic             w_accept;
    logic             w_count_frame;
    logic             w_set_timeout;
    logic [FRM_W-1:0] w_frames_inc;
    logic             w_int_reached;
    logic             w_to_hit;

    assign w_frames_inc = r_frames + c_frm_one;

    // The interval counter holds (cycles since capture). The next capture is
    // allowed at capture + interval, so the decision one cycle earlier looks
    // at counter + 1. Extended by one bit so a saturated counter still passes.
    assign w_int_reached = ({1'b0, r_int_cnt} + c_cnt_one_ext) >= {1'b0, r_interval_lat};

    assign w_to_hit = (r_timeout_lat != c_cnt_zero) && (r_to_cnt == r_timeout_lat);

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_count_frame = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) w_next = FINISH;
                else       w_next = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                // Priority: abort > frame_done > watchdog.
                if (abort) begin
                    w_next = FINISH;
                end else if (frame_done) begin
                    w_count_frame = 1'b1;
                    if ((r_count_lat != c_frm_zero) && (w_frames_inc == r_count_lat))
                        w_next = FINISH;
                    else if (w_int_reached)
                        w_next = CAPTURE;
                    else
                        w_next = WAIT_INTERVAL;
                end else if (w_to_hit) begin
                    w_set_timeout = 1'b1;
                    w_next        = FINISH;
                end
            end
            WAIT_INTERVAL: begin
                if (abort)              w_next = FINISH;
                else if (w_int_reached) w_next = CAPTURE;
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_count_lat    <= c_frm_zero;
            r_interval_lat <= c_cnt_zero;
            r_timeout_lat  <= c_cnt_zero;
            r_int_cnt      <= c_cnt_zero;
            r_to_cnt       <= c_cnt_zero;
            r_frames       <= c_frm_zero;
            r_capture      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            r_capture <= (w_next == CAPTURE);
            r_busy    <= (w_next != IDLE);
            r_done    <= (w_next == FINISH);

            if (w_accept) begin
                r_count_lat    <= frame_count;
                r_interval_lat <= frame_interval;
                r_timeout_lat  <= timeout_cycles;
                r_frames       <= c_frm_zero;
                r_timeout_err  <= 1'b0;
            end

            if (w_count_frame) begin
                r_frames <= w_frames_inc;
            end

            if (w_set_timeout) begin
                r_timeout_err <= 1'b1;
            end

            case (r_state)
                CAPTURE: begin
                    r_int_cnt <= c_cnt_one;
                    r_to_cnt  <= c_cnt_one;
                end
                WAIT_FRAME: begin
                    if (r_int_cnt != c_cnt_max) r_int_cnt <= r_int_cnt + c_cnt_one;
                    if (r_to_cnt  != c_cnt_max) r_to_cnt  <= r_to_cnt  + c_cnt_one;
                end
                WAIT_INTERVAL: begin
                    if (r_int_cnt != c_cnt_max) r_int_cnt <= r_int_cnt + c_cnt_one;
                end
                default: begin
                end
            endcase
        end
    end

    assign capture     = r_capture;
    assign busy        = r_busy;
    assign done        = r_done;
    assign frames_done = r_frames;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_sequencer
//  Purpose  : Directed self-checking bench for capture_sequencer. Frame
//             counter width is reduced to 8 bits so the continuous-mode wrap
//             is reached in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int CNT_W = 32;
    localparam int FRM_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [FRM_W-1:0] frame_count;
    logic [CNT_W-1:0] frame_interval;
    logic [CNT_W-1:0] timeout_cycles;
    logic             frame_done;
    logic             capture;
    logic             busy;
    logic             done;
    logic [FRM_W-1:0] frames_done;
    logic             timeout_err;

    int cyc;
    int checks;
    int errors;
    int cap_total;
    int done_total;
    int c;
    int t;
    int at;
    int cap_base;
    int done_base;

    capture_sequencer #(
        .CNT_W(CNT_W),
        .FRM_W(FRM_W)
    ) dut (
        .sys_clk        (clk),
        .sys_rst        (rst),
        .start          (start),
        .abort          (abort),
        .frame_count    (frame_count),
        .frame_interval (frame_interval),
        .timeout_cycles (timeout_cycles),
        .frame_done     (frame_done),
        .capture        (capture),
        .busy           (busy),
        .done           (done),
        .frames_done    (frames_done),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled mid-cycle.
    initial begin
        cap_total  = 0;
        done_total = 0;
    end
    always @(negedge clk) begin
        if (capture === 1'b1) cap_total++;
        if (done === 1'b1)    done_total++;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive frame_done during cycle 'target', return one cycle later.
    task automatic pulse_done_at(input int target);
        while (cyc < target) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // sel 0: capture, sel 1: done. Returns cycle number or -1 on timeout.
    task automatic wait_sig(input int sel, input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel == 0 && capture === 1'b1) || (sel == 1 && done === 1'b1)) begin
                when = cyc;
                break;
            end
        end
    endtask

    task automatic do_start(input int fc, input int iv, input int to);
        frame_count    = FRM_W'(fc);
        frame_interval = CNT_W'(iv);
        timeout_cycles = CNT_W'(to);
        start          = 1'b1;
        t              = cyc;
        tick();
        start          = 1'b0;
        c              = cyc;
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; frame_done = 1'b0;
        frame_count = '0; frame_interval = '0; timeout_cycles = '0;
        tick(); tick();
        chk("rst_capture", 32'(capture), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_frames", 32'(frames_done), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;
        tick(); tick();

        // ---- 3 frames, interval 100, frame_done 20 after each capture ----
        cap_base = cap_total;
        do_start(3, 100, 0);
        chk("t1_cap1_high", 32'(capture), 1);
        chk("t1_busy", 32'(busy), 1);
        // start while busy, with different config, must be ignored
        while (cyc < c + 5) tick();
        start = 1'b1; frame_count = 8'd1; frame_interval = 32'd5;
        tick();
        start = 1'b0;
        pulse_done_at(c + 20);
        chk("t1_frames_after1", 32'(frames_done), 1);
        wait_sig(0, 200, at);
        chk("t1_cap2_cycle", 32'(at), 32'(t + 101));
        c = at;
        pulse_done_at(c + 20);
        wait_sig(0, 200, at);
        chk("t1_cap3_cycle", 32'(at), 32'(t + 201));
        c = at;
        pulse_done_at(c + 20);
        chk("t1_done_cycle", 32'(done), 1);
        chk("t1_done_at", 32'(cyc), 32'(t + 222));
        chk("t1_frames", 32'(frames_done), 3);
        chk("t1_timeout_err", 32'(timeout_err), 0);
        tick();
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_done_low", 32'(done), 0);
        tick(); tick();
        chk("t1_capture_count", 32'(cap_total - cap_base), 3);

        // frame_done in IDLE is not counted
        frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
        chk("idle_frame_done_ignored", 32'(frames_done), 3);
        chk("idle_busy", 32'(busy), 0);

        // ---- 2 frames, interval 10, frame_done 50 after capture ----
        do_start(2, 10, 0);
        chk("t2_frames_cleared", 32'(frames_done), 0);
        pulse_done_at(c + 50);
        chk("t2_cap2_at_c51", 32'(capture), 1);
        c = cyc;
        pulse_done_at(c + 7);
        chk("t2_done", 32'(done), 1);
        chk("t2_frames", 32'(frames_done), 2);
        tick(); tick();

        // ---- watchdog: 4 frames, timeout 30, no frame_done ----
        cap_base = cap_total;
        do_start(4, 5, 30);
        wait_sig(1, 100, at);
        chk("t3_done_cycle", 32'(at), 32'(c + 31));
        chk("t3_timeout_err", 32'(timeout_err), 1);
        chk("t3_frames", 32'(frames_done), 0);
        tick();
        chk("t3_busy_low", 32'(busy), 0);
        tick(); tick();
        chk("t3_sticky", 32'(timeout_err), 1);
        chk("t3_one_capture", 32'(cap_total - cap_base), 1);

        // ---- frame_done exactly at c + timeout is counted ----
        do_start(1, 0, 30);
        chk("t3b_err_cleared", 32'(timeout_err), 0);
        pulse_done_at(c + 30);
        chk("t3b_done", 32'(done), 1);
        chk("t3b_frames", 32'(frames_done), 1);
        chk("t3b_no_err", 32'(timeout_err), 0);
        tick(); tick();

        // ---- abort beats frame_done after 2 frames ----
        cap_base = cap_total;
        do_start(5, 0, 0);
        pulse_done_at(c + 2);
        chk("t4_cap2_back_to_back", 32'(capture), 1);
        c = cyc;
        pulse_done_at(c + 2);
        chk("t4_cap3", 32'(capture), 1);
        c = cyc;
        while (cyc < c + 2) tick();
        abort = 1'b1; frame_done = 1'b1;
        tick();
        abort = 1'b0; frame_done = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_frames", 32'(frames_done), 2);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_busy_low", 32'(busy), 0);
        chk("t4_captures", 32'(cap_total - cap_base), 3);

        // ---- continuous mode, wrap of frames_done ----
        cap_base  = cap_total;
        done_base = done_total;
        do_start(0, 1, 0);
        for (int i = 0; i < 257; i++) begin
            pulse_done_at(c + 3);
            c = c + 4;
            if (i == 255) begin
                chk("t5_wrap_zero", 32'(frames_done), 0);
                chk("t5_busy_at_wrap", 32'(busy), 1);
            end
        end
        chk("t5_frames_wrapped", 32'(frames_done), 1);
        chk("t5_capture_now", 32'(capture), 1);
        chk("t5_no_done", 32'(done_total - done_base), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_done", 32'(done), 1);
        tick(); tick(); tick();
        chk("t5_busy_low", 32'(busy), 0);
        chk("t5_captures", 32'(cap_total - cap_base), 258);

        // ---- reset during WAIT_INTERVAL ----
        do_start(3, 100, 0);
        pulse_done_at(c + 5);
        tick(); tick();
        chk("t6_busy_before_rst", 32'(busy), 1);
        done_base = done_total;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_capture", 32'(capture), 0);
        chk("t6_rst_frames", 32'(frames_done), 0);
        chk("t6_rst_done", 32'(done), 0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t6_no_done_pulse", 32'(done_total - done_base), 0);
        do_start(2, 0, 0);
        chk("t6_restart_capture", 32'(capture), 1);
        chk("t6_restart_busy", 32'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capture_sequencer.md
# capture_sequencer

- Multi-frame acquisition scheduler that drives the single-cycle `capture` pulse into the camera capture controller.
- Acquires a programmed number of frames, spaced at least `frame_interval` cycles apart (measured capture pulse to capture pulse).
- Waits for each frame's DMA completion (`frame_done`, the S2MM tlast handshake) before issuing the next capture.
- Enforces a per-frame watchdog, supports abort, and reports progress and status to software.

## Interface
Parameters:
- CNT_W, 32, width of the interval and timeout counters and their configuration inputs.
- FRM_W, 16, width of the frame counters.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a sequence when idle.
- abort  in  1  pulse; terminates the active sequence.
- frame_count  in  FRM_W  frames to acquire; 0 means continuous until abort.
- frame_interval  in  CNT_W  minimum cycles from one capture pulse to the next.
- timeout_cycles  in  CNT_W  maximum cycles from a capture pulse to `frame_done`; 0 disables the watchdog.
- frame_done  in  1  pulse from the DMA path: tvalid & tready & tlast.
- capture  out  1  registered single-cycle pulse to the capture controller.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  single-cycle pulse at sequence end (normal, timeout, or abort).
- frames_done  out  FRM_W  frames completed in the current sequence.
- timeout_err  out  1  sticky; cleared by the next accepted start.

## Operation
- All outputs reset to 0; state resets to IDLE. Reset mid-sequence returns to IDLE immediately, with no done pulse.
- States are IDLE, CAPTURE, WAIT_FRAME, WAIT_INTERVAL, FINISH.
- IDLE:
  - On start: latch frame_count, frame_interval, and timeout_cycles; clear frames_done and timeout_err; go to CAPTURE.
  - abort is ignored. frame_done is ignored and not counted.
- CAPTURE:
  - capture = 1 for this cycle only.
  - Interval and timeout counters load 1.
  - Go to WAIT_FRAME.
- WAIT_FRAME:
  - Both counters increment each cycle, saturating at all-ones.
  - On frame_done: frames_done += 1 (modulo 2^FRM_W).
    - If latched count ≠ 0 and new value == latched count: go to FINISH.
    - Otherwise, if the interval counter ≥ latched interval: go to CAPTURE.
    - Otherwise: go to WAIT_INTERVAL.
  - On timeout: if the watchdog is enabled, frame_done is absent, and the timeout counter == latched timeout, set timeout_err = 1 and go to FINISH.
- WAIT_INTERVAL:
  - The interval counter keeps incrementing.
  - When it is ≥ latched interval: go to CAPTURE.
  - frame_done in this state is ignored.
- FINISH: done = 1 for one cycle; go to IDLE.
- Priorities and corner cases:
  - abort in any state other than IDLE or FINISH forces FINISH next cycle.
  - abort beats frame_done in the same cycle: that frame is not counted.
  - frame_done beats the watchdog in the same cycle.
  - start while busy is ignored. Configuration inputs may change while busy; the latched values are used.
  - frame_interval values 0 and 1 behave identically: back-to-back frames are limited only by frame_done.
  - In continuous mode, frames_done wraps from 2^FRM_W−1 to 0 without ending the sequence.

## Timing
- start sampled at cycle t: capture is high at t+1 and busy is high from t+1.
- First capture at cycle c, frame_done at cycle f: the next capture occurs at max(c + frame_interval, f + 1).
- frames_done updates at f+1.
- On the last frame: done is high at f+1, busy is low at f+2, and start is accepted again from f+2.
- Watchdog: with no frame_done, timeout_err rises at c + timeout_cycles + 1, coincident with done. frame_done at exactly c + timeout_cycles is counted normally.
- abort sampled at cycle a: done at a+1, busy low at a+2, no further capture after cycle a.

## Test plan
- frame_count=3, interval=100, timeout=0, frame_done 20 cycles after each capture:
  - captures at t+1, t+101, t+201;
  - done at t+222;
  - frames_done=3, timeout_err=0.
- frame_count=2, interval=10, frame_done 50 cycles after capture c:
  - second capture at c+51;
  - done one cycle after the second frame_done.
- frame_count=4, timeout=30, frame_done never arrives:
  - timeout_err=1 and done at c+31;
  - frames_done=0, exactly one capture.
- frame_count=5, abort and frame_done asserted in the same WAIT_FRAME cycle after 2 frames:
  - frames_done stays 2, done next cycle, no further capture.
- frame_count=0, interval=1, frame_done 3 cycles after each capture, run for 65537 frames (FRM_W=16):
  - frames_done wraps to 1, no done;
  - abort then yields done.
- sys_rst asserted during WAIT_INTERVAL:
  - all outputs 0 immediately, no done pulse;
  - a new start after release gives capture one cycle later.
